video_timing: RTL

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_pkg.sv | 28 ++
 rtl/video_timing_if.sv | 15 +
 rtl/video_counter.sv | 39 +++
 rtl/video_timing.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster timing defaults and small helpers for the video pipeline
// (timing generator, tile stage, top level).
package video_pkg;

    localparam int DEF_CLK_DIV  = 10;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 14;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 9;

    typedef logic [7:0] pix8_t;

    // Half-open window test lo <= pos < hi.
    function automatic logic in_window(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/video_timing_if.sv
// Coordinate/colour handshake between the timing generator and the tile stage.
interface video_timing_if;
    import video_pkg::*;

    pix8_t hh;
    pix8_t vv;
    logic  tile_done;
    pix8_t tile_r;
    pix8_t tile_g;
    pix8_t tile_b;

    modport master (output hh, vv, input tile_done, tile_r, tile_g, tile_b);
    modport slave  (input hh, vv, output tile_done, tile_r, tile_g, tile_b);

endinterface

// File: rtl/video_counter.sv
// Wrap counter 0..MAX advancing on en; carry flags the enabled wrap.
module video_counter
    import video_pkg::*;
#(
    parameter int MAX = DEF_H_TOTAL - 1,
    parameter int W   = CNT_W
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         carry
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == W'(MAX));
    assign carry  = en & at_max;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = at_max ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: pixel divider, h/v counters, sync decode and the
// registered output pixel stage fed by the tile stage.
module video_timing
    import video_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
)
(
    input  logic           clk,
    input  logic           rst_n,
    video_timing_if.master tile,
    output logic           ce_pix,
    output pix8_t          r,
    output pix8_t          g,
    output pix8_t          b,
    output logic           hsync,
    output logic           vsync,
    output logic           hblank,
    output logic           vblank,
    output logic           de,
    output logic           frame_start,
    output logic           underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] hcount, vcount;
    logic             h_at_max, h_carry;
    logic             v_at_max_unused, v_carry_unused;

    int               h_pos, v_pos;
    logic             h_blank_raw, v_blank_raw, h_sync_raw, v_sync_raw, pix_active;

    pix8_t            r_q, r_d, g_q, g_d, b_q, b_d;
    logic             hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d, de_q, de_d;
    logic             fs_q, fs_d, und_q, und_d;

    assign ce_pix = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = ce_pix ? '0 : div_q + DIV_W'(1);
    end

    video_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_hcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ce_pix),
        .count  (hcount),
        .at_max (h_at_max),
        .carry  (h_carry)
    );

    video_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_vcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (h_carry),
        .count  (vcount),
        .at_max (v_at_max_unused),
        .carry  (v_carry_unused)
    );

    always_comb begin
        h_pos       = int'(hcount);
        v_pos       = int'(vcount);
        h_blank_raw = in_window(h_pos, H_ACTIVE, H_TOTAL);
        v_blank_raw = in_window(v_pos, V_ACTIVE, V_TOTAL);
        h_sync_raw  = in_window(h_pos, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
        v_sync_raw  = in_window(v_pos, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
        pix_active  = ~h_blank_raw & ~v_blank_raw;
    end

    // Coordinates follow the counters, so they move only after a ce_pix edge.
    assign tile.hh = h_blank_raw ? 8'd0 : hcount[7:0];
    assign tile.vv = v_blank_raw ? 8'd0 : vcount[7:0];

    always_comb begin
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        hb_d  = hb_q;
        vb_d  = vb_q;
        de_d  = de_q;
        fs_d  = 1'b0;
        und_d = und_q;
        if (ce_pix) begin
            r_d   = (pix_active && tile.tile_done) ? tile.tile_r : 8'd0;
            g_d   = (pix_active && tile.tile_done) ? tile.tile_g : 8'd0;
            b_d   = (pix_active && tile.tile_done) ? tile.tile_b : 8'd0;
            hs_d  = h_sync_raw;
            vs_d  = v_sync_raw;
            hb_d  = h_blank_raw;
            vb_d  = v_blank_raw;
            de_d  = pix_active;
            fs_d  = (hcount == '0) && (vcount == '0);
            und_d = und_q | (pix_active & ~tile.tile_done);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            hb_q  <= 1'b0;
            vb_q  <= 1'b0;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            und_q <= 1'b0;
        end else begin
            div_q <= div_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            hb_q  <= hb_d;
            vb_q  <= vb_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
            und_q <= und_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign hblank      = hb_q;
    assign vblank      = vb_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign underrun    = und_q;

endmodule
